// File: rtl/exponent_adder_serial.sv
// -----------------------------------------------------------------------------
// exponent_adder_serial
//
// Bit-serial adder for two biased floating-point exponents. One operand pair
// is accepted in IDLE. The pair is then added one bit per clock, LSB first,
// over EXP_W cycles in ADD. The result is held in DONE until the downstream
// bias subtractor takes it. A flag marks pairs where either exponent is
// all-zeros (zero/denormal) or all-ones (inf/NaN), so downstream logic can
// bypass normal handling.
//
// Ports
//   clk        : single clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : an operand pair is presented on exp_a / exp_b
//   in_ready   : block is idle and can accept a pair
//   exp_a      : biased exponent of operand A   [EXP_W-1:0]
//   exp_b      : biased exponent of operand B   [EXP_W-1:0]
//   out_valid  : sum / special are valid (DONE state)
//   out_ready  : downstream accepts the result
//   sum        : exp_a + exp_b, carry in MSB   [EXP_W:0]
//   special    : either captured exponent was all-zeros or all-ones
//   busy       : FSM is not in IDLE
// -----------------------------------------------------------------------------
module exponent_adder_serial #(
  parameter int EXP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [EXP_W-1:0] exp_a,
  input  logic [EXP_W-1:0] exp_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [EXP_W:0]   sum,
  output logic             special,
  output logic             busy
);

  localparam int CNT_W = (EXP_W > 1) ? $clog2(EXP_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(EXP_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [EXP_W-1:0] a_q, b_q;
  logic [EXP_W:0]   sum_q;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             special_q;

  logic accept;
  logic last_bit;
  logic fa_sum, fa_carry;
  logic special_in;

  assign accept   = in_valid && (state == IDLE);
  assign last_bit = (cnt == LAST_BIT);

  // One full-adder slice, applied to the bit selected by cnt.
  assign fa_sum   = a_q[cnt] ^ b_q[cnt] ^ carry;
  assign fa_carry = (a_q[cnt] & b_q[cnt]) | (carry & (a_q[cnt] ^ b_q[cnt]));

  assign special_in = (exp_a == '0) || (exp_a == '1) ||
                      (exp_b == '0) || (exp_b == '1);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <=. Every flop then
  // samples the pre-edge values, so the order of statements does not matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top keeps this block free of latches
  // on every path through the case.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (in_valid)  state_nx = ADD;
      ADD:     if (last_bit)  state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default:                state_nx = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs (Moore)
  // ---------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Operand registers
  // ---------------------------------------------------------------------------
  // NOTE: the operand copies have no reset. They are always loaded at capture
  // before anything reads them, so a reset would only add routing.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= exp_a;
      b_q <= exp_b;
    end
  end

  // ---------------------------------------------------------------------------
  // Serial datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= '0;
      special_q <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
    end else if (accept) begin
      sum_q     <= '0;
      special_q <= special_in;
      carry     <= 1'b0;
      cnt       <= '0;
    end else if (state == ADD) begin
      sum_q[cnt] <= fa_sum;
      carry      <= fa_carry;
      cnt        <= cnt + CNT_W'(1);
      // The final carry-out becomes the MSB, so the sum can never overflow.
      if (last_bit) sum_q[EXP_W] <= fa_carry;
    end
  end

  assign sum     = sum_q;
  assign special = special_q;

endmodule

// File: tb/tb_exponent_adder_serial.sv
// -----------------------------------------------------------------------------
// Testbench for exponent_adder_serial. Expected values come from plain
// integer addition and the all-zeros / all-ones rule applied to the operands.
// -----------------------------------------------------------------------------
module tb_exponent_adder_serial;

  localparam int EXP_W   = 8;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic             out_valid;
  logic             out_ready;
  logic [EXP_W:0]   sum;
  logic             special;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  exponent_adder_serial #(.EXP_W(EXP_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .exp_a     (exp_a),
    .exp_b     (exp_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .special   (special),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model
  function automatic logic [EXP_W:0] ref_sum(input int a, input int b);
    int s;
    s = a + b;
    return s[EXP_W:0];
  endfunction

  function automatic logic ref_special(input int a, input int b);
    return (a == 0) || (a == EXP_MAX) || (b == 0) || (b == EXP_MAX);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and clock it in. The caller must know the DUT is in IDLE.
  task automatic accept_op(input int a, input int b, input string name);
    exp_a    = EXP_W'(a);
    exp_b    = EXP_W'(b);
    in_valid = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s accept: in_ready=%b required 1", name, in_ready);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s capture: busy=%b in_ready=%b required busy=1 in_ready=0",
               name, busy, in_ready);
    end
  endtask

  // Wait for the result, measure latency from the accepting edge, check it.
  // If hand_off is set, also perform the handoff.
  task automatic finish_op(input int a, input int b, input string name, input bit hand_off);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 50) begin
      tick();
      lat++;
    end
    checks++;
    if (lat != EXP_W) begin
      failures++;
      $display("FAIL %s latency: got %0d edges required %0d", name, lat, EXP_W);
    end
    checks++;
    if (sum !== ref_sum(a, b) || special !== ref_special(a, b)) begin
      failures++;
      $display("FAIL %s result: sum=%h special=%b required sum=%h special=%b",
               name, sum, special, ref_sum(a, b), ref_special(a, b));
    end
    if (hand_off) begin
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        failures++;
        $display("FAIL %s handoff: out_valid=%b busy=%b in_ready=%b required 0/0/1",
                 name, out_valid, busy, in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    exp_a     = '0;
    exp_b     = '0;
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
        sum !== '0 || special !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: in_ready=%b busy=%b out_valid=%b sum=%h special=%b required 1/0/0/000/0",
               in_ready, busy, out_valid, sum, special);
    end
    #4 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    int va[5] = '{127, 255, 128, 0, 0};
    int vb[5] = '{127, 255, 127, 0, 200};
    for (int i = 0; i < 5; i++) begin
      accept_op(va[i], vb[i], $sformatf("dir%0d", i));
      finish_op(va[i], vb[i], $sformatf("dir%0d", i), 1'b1);
    end
    // Sum stays put in IDLE after the handoff.
    tick();
    checks++;
    if (sum !== ref_sum(0, 200)) begin
      failures++;
      $display("FAIL idle_retain: sum=%h required %h", sum, ref_sum(0, 200));
    end
  endtask

  task automatic test_backpressure();
    accept_op(50, 60, "bp");
    finish_op(50, 60, "bp", 1'b0);
    // New operands are offered while the result is stalled.
    exp_a     = 8'd255;
    exp_b     = 8'd0;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          sum !== ref_sum(50, 60) || special !== ref_special(50, 60)) begin
        failures++;
        $display("FAIL bp_hold%0d: out_valid=%b in_ready=%b sum=%h special=%b required 1/0/%h/%b",
                 i, out_valid, in_ready, sum, special, ref_sum(50, 60), ref_special(50, 60));
      end
    end
    out_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || sum !== ref_sum(50, 60)) begin
      failures++;
      $display("FAIL bp_release: busy=%b out_valid=%b sum=%h required 0/0/%h",
               busy, out_valid, sum, ref_sum(50, 60));
    end
    // The pair offered during the handoff cycle must not have started an op.
    tick();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_capture: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    accept_op(10, 20, "rst_mid");
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== '0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_mid_async: out_valid=%b sum=%h busy=%b in_ready=%b required 0/000/0/1",
               out_valid, sum, busy, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // The first edge after release must accept.
    accept_op(200, 100, "rst_after");
    finish_op(200, 100, "rst_after", 1'b1);
  endtask

  task automatic test_stream();
    int qa[$];
    int qb[$];
    int results;
    int cycle;
    int last_out;
    int ea, eb;
    results  = 0;
    cycle    = 0;
    last_out = -1;
    exp_a     = EXP_W'($urandom);
    exp_b     = EXP_W'($urandom);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    while (results < 20 && cycle < 400) begin
      bit acc;
      acc = in_ready && in_valid;
      if (acc) begin
        qa.push_back(int'(exp_a));
        qb.push_back(int'(exp_b));
      end
      if (out_valid === 1'b1) begin
        checks++;
        if (qa.size() == 0) begin
          failures++;
          $display("FAIL stream_extra: result with no accepted pair at cycle %0d", cycle);
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          if (sum !== ref_sum(ea, eb) || special !== ref_special(ea, eb)) begin
            failures++;
            $display("FAIL stream%0d: %0d+%0d sum=%h special=%b required %h/%b",
                     results, ea, eb, sum, special, ref_sum(ea, eb), ref_special(ea, eb));
          end
        end
        if (last_out >= 0) begin
          checks++;
          if (cycle - last_out != EXP_W + 2) begin
            failures++;
            $display("FAIL stream_rate%0d: gap=%0d required %0d",
                     results, cycle - last_out, EXP_W + 2);
          end
        end
        last_out = cycle;
        results++;
      end
      tick();
      cycle++;
      if (acc) begin
        exp_a = EXP_W'($urandom);
        exp_b = EXP_W'($urandom);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (results != 20) begin
      failures++;
      $display("FAIL stream_timeout: got %0d results required 20", results);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_stream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
